fadd_issue_arbiter: RTL and testbench

Shares one instance of the dual-mode pipelined FADD between two requesters. The block arbitrates requests round-robin, issues at most one operation per cycle into the FADD, and tracks each in-flight operation's owner in a shadow pipeline. It returns each result to its owner with per-requester backpressure, stalling the whole FADD through its enable input when the owner of the result at the output is not ready. It sits between the requester front-ends and the FADD, and it also sequences the FADD's clear after reset and a drain-to-idle on request.

---
 rtl/fadd_issue_arbiter.sv | 124 ++++++++++++
 tb/tb_fadd_issue_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fadd_issue_arbiter.sv
// fadd_issue_arbiter: shares one pipelined FADD between two requesters.
// Round-robin issue, owner tracking in a shadow pipeline aligned with the
// FADD register stages, per-owner backpressure via the FADD enable, and a
// clear sequence after reset.
module fadd_issue_arbiter #(
  parameter int LATENCY = 5,
  parameter int DW      = 64
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [1:0]    i_req_valid,
  input  logic [1:0]    i_req_mode,
  input  logic [DW-1:0] i_req_A0,
  input  logic [DW-1:0] i_req_B0,
  input  logic [DW-1:0] i_req_A1,
  input  logic [DW-1:0] i_req_B1,
  output logic [1:0]    o_req_ready,
  output logic [1:0]    o_rsp_valid,
  input  logic [1:0]    i_rsp_ready,
  output logic [DW-1:0] o_rsp_data,
  input  logic          i_drain,
  output logic          o_idle,
  output logic          o_fadd_mode,
  output logic [DW-1:0] o_fadd_A,
  output logic [DW-1:0] o_fadd_B,
  output logic          o_fadd_en,
  output logic          o_fadd_clr,
  input  logic [DW-1:0] i_fadd_res
);

  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

  localparam int CW = $clog2(LATENCY + 1);

  state_t              r_state;
  logic [CW-1:0]       r_init_cnt;
  logic                r_fadd_clr;
  logic [LATENCY-1:0]  r_sh_valid;
  logic [LATENCY-1:0]  r_sh_id;
  logic                r_rr_last;

  logic                w_tail_valid;
  logic                w_tail_id;
  logic                w_en;
  logic [1:0]          w_elig;
  logic                w_issue;
  logic                w_gnt_id;
  logic                w_sel1;

  // Tail of the shadow pipeline describes the result currently at the FADD output.
  assign w_tail_valid = r_sh_valid[LATENCY-1];
  assign w_tail_id    = r_sh_id[LATENCY-1];

  // Freeze the whole FADD when the owner of the output result cannot take it.
  assign w_en = !(w_tail_valid && !i_rsp_ready[w_tail_id]);

  // Only requesters seen while running, not draining and not stalled compete.
  assign w_elig   = (r_state == S_RUN && !i_drain && w_en) ? i_req_valid : 2'b00;
  assign w_issue  = |w_elig;
  // On contention the loser of the previous issue wins; otherwise the lone requester.
  assign w_gnt_id = (w_elig == 2'b11) ? ~r_rr_last : w_elig[1];
  assign w_sel1   = w_issue && w_gnt_id;

  assign o_req_ready = w_issue ? (w_gnt_id ? 2'b10 : 2'b01) : 2'b00;
  assign o_rsp_valid = w_tail_valid ? (w_tail_id ? 2'b10 : 2'b01) : 2'b00;
  assign o_rsp_data  = i_fadd_res;

  // Idle operands default to requester 0; entry 0 is invalid in that case.
  assign o_fadd_mode = w_sel1 ? i_req_mode[1] : i_req_mode[0];
  assign o_fadd_A    = w_sel1 ? i_req_A1 : i_req_A0;
  assign o_fadd_B    = w_sel1 ? i_req_B1 : i_req_B0;
  assign o_fadd_en   = w_en;
  assign o_fadd_clr  = r_fadd_clr;

  assign o_idle = (r_state == S_RUN) && !(|r_sh_valid) && !w_issue;

  // Control FSM: hold the FADD in clear for LATENCY cycles, then run.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_INIT;
      r_init_cnt <= '0;
      r_fadd_clr <= 1'b1;
    end else begin
      case (r_state)
        S_INIT: begin
          if (r_init_cnt == CW'(LATENCY - 1)) begin
            r_state    <= S_RUN;
            r_fadd_clr <= 1'b0;
          end else begin
            r_init_cnt <= r_init_cnt + CW'(1);
          end
        end
        S_RUN: begin
          r_fadd_clr <= 1'b0;
        end
        default: begin
          r_state    <= S_INIT;
          r_fadd_clr <= 1'b1;
        end
      endcase
    end
  end

  // Shadow pipeline of {valid, owner}; moves in lock-step with the FADD enable.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sh_valid <= '0;
      r_sh_id    <= '0;
    end else if (w_en) begin
      r_sh_valid <= {r_sh_valid[LATENCY-2:0], w_issue};
      r_sh_id    <= {r_sh_id[LATENCY-2:0], w_gnt_id};
    end
  end

  // Round-robin pointer remembers the last requester that actually issued.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rr_last <= 1'b1;
    end else if (w_issue) begin
      r_rr_last <= w_gnt_id;
    end
  end

endmodule

// File: tb/tb_fadd_issue_arbiter.sv
// Bench for fadd_issue_arbiter: behavioural FADD stand-in, queue-based
// scoreboard checked every cycle, a vector table and directed sequences.
module tb_fadd_issue_arbiter;

  localparam int LATENCY = 5;
  localparam int DW      = 64;

  logic          clk;
  logic          rst_n;
  logic [1:0]    req_valid;
  logic [1:0]    req_mode;
  logic [DW-1:0] req_A0, req_B0, req_A1, req_B1;
  logic [1:0]    req_ready;
  logic [1:0]    rsp_valid;
  logic [1:0]    rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          drain;
  logic          idle;
  logic          fadd_mode;
  logic [DW-1:0] fadd_A, fadd_B;
  logic          fadd_en;
  logic          fadd_clr;
  logic [DW-1:0] fadd_res;

  int n_tests = 0;
  int n_fail  = 0;

  fadd_issue_arbiter #(.LATENCY(LATENCY), .DW(DW)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .i_req_mode  (req_mode),
    .i_req_A0    (req_A0),
    .i_req_B0    (req_B0),
    .i_req_A1    (req_A1),
    .i_req_B1    (req_B1),
    .o_req_ready (req_ready),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_data  (rsp_data),
    .i_drain     (drain),
    .o_idle      (idle),
    .o_fadd_mode (fadd_mode),
    .o_fadd_A    (fadd_A),
    .o_fadd_B    (fadd_B),
    .o_fadd_en   (fadd_en),
    .o_fadd_clr  (fadd_clr),
    .i_fadd_res  (fadd_res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- floating-point helpers ----------------
  function automatic real sp2real(input logic [31:0] s);
    logic [63:0] d;
    if (s[30:23] == 8'd0) d = {s[31], 63'd0};
    else d = {s[31], 11'({3'b000, s[30:23]}) + 11'd896, s[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] real2sp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:52] == 11'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [63:0] fadd_fn(input logic m, input logic [63:0] a, input logic [63:0] b);
    if (m) return $realtobits($bitstoreal(a) + $bitstoreal(b));
    return {real2sp(sp2real(a[63:32]) + sp2real(b[63:32])),
            real2sp(sp2real(a[31:0]) + sp2real(b[31:0]))};
  endfunction

  // ---------------- FADD stand-in: LATENCY enabled register stages ----------------
  bit [63:0] p [LATENCY];
  assign fadd_res = p[LATENCY-1];
  always @(posedge clk) begin
    if (fadd_clr) begin
      for (int i = 0; i < LATENCY; i++) p[i] <= '0;
    end else if (fadd_en) begin
      p[0] <= fadd_fn(fadd_mode, fadd_A, fadd_B);
      for (int i = 1; i < LATENCY; i++) p[i] <= p[i-1];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard: queue of in-flight operations with ages ----------------
  typedef struct {
    bit          id;
    logic [63:0] data;
    int          stage;
  } fl_t;
  fl_t q[$];
  int  m_cnt  = 0;
  bit  m_last = 1'b1;

  always @(negedge clk) begin : sb
    bit          run, head_vis, stall, issue, gid;
    logic [1:0]  elig, exp_rv, exp_rdy;
    fl_t         item;
    if (!rst_n) begin
      q.delete();
      m_cnt  = 0;
      m_last = 1'b1;
      check("rst_req_ready", 64'(req_ready), 64'd0);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_idle", 64'(idle), 64'd0);
      check("rst_clr", 64'(fadd_clr), 64'd1);
      check("rst_en", 64'(fadd_en), 64'd1);
    end else begin
      run      = (m_cnt >= LATENCY);
      head_vis = (q.size() > 0) && (q[0].stage == LATENCY - 1);
      stall    = head_vis && !rsp_ready[q[0].id];
      exp_rv   = head_vis ? (q[0].id ? 2'b10 : 2'b01) : 2'b00;
      elig     = (run && !drain && !stall) ? req_valid : 2'b00;
      issue    = (elig != 2'b00);
      gid      = (elig == 2'b11) ? !m_last : elig[1];
      exp_rdy  = issue ? (gid ? 2'b10 : 2'b01) : 2'b00;
      check("sb_req_ready", 64'(req_ready), 64'(exp_rdy));
      check("sb_rsp_valid", 64'(rsp_valid), 64'(exp_rv));
      check("sb_fadd_en", 64'(fadd_en), 64'(!stall));
      check("sb_fadd_clr", 64'(fadd_clr), 64'(!run));
      check("sb_idle", 64'(idle), 64'(run && q.size() == 0 && !issue));
      if (head_vis) check("sb_rsp_data", rsp_data, q[0].data);
      if (!run) m_cnt++;
      if (!stall) begin
        if (head_vis) begin
          $display("[TB] rsp r%0d data=%h", q[0].id, q[0].data);
          void'(q.pop_front());
        end
        for (int i = 0; i < q.size(); i++) begin
          item = q[i];
          item.stage++;
          q[i] = item;
        end
        if (issue) begin
          item.id    = gid;
          item.data  = gid ? fadd_fn(req_mode[1], req_A1, req_B1)
                           : fadd_fn(req_mode[0], req_A0, req_B0);
          item.stage = 0;
          q.push_back(item);
          m_last = gid;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {
    bit          id;
    bit          mode;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
  } vec_t;
  vec_t tbl [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit id, input bit m, input logic [63:0] a, input logic [63:0] b);
    if (id) begin req_mode[1] = m; req_A1 = a; req_B1 = b; end
    else    begin req_mode[0] = m; req_A0 = a; req_B0 = b; end
  endtask

  task automatic do_op(input int i);
    int         k;
    logic [1:0] oh;
    set_req(tbl[i].id, tbl[i].mode, tbl[i].a, tbl[i].b);
    oh = tbl[i].id ? 2'b10 : 2'b01;
    req_valid = oh;
    #1;
    k = 0;
    while (req_ready !== oh && k < 20) begin tick(); k++; end
    check("op_accept", 64'(req_ready), 64'(oh));
    tick();
    req_valid = 2'b00;
    k = 1;
    while (rsp_valid === 2'b00 && k < 20) begin tick(); k++; end
    check("op_latency", 64'(k), 64'(LATENCY));
    check("op_rsp_valid", 64'(rsp_valid), 64'(oh));
    check("op_rsp_data", rsp_data, tbl[i].exp);
    tick();
  endtask

  function automatic logic [63:0] rnd_operand(input bit m);
    logic [63:0] r;
    r = {$urandom, $urandom};
    if (m) return {r[63], 11'h3F0 + 11'($urandom_range(0, 15)), r[51:0]};
    return {r[63], 8'h78 + 8'($urandom_range(0, 15)), r[54:32],
            r[31], 8'h78 + 8'($urandom_range(0, 15)), r[22:0]};
  endfunction

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int k, nrsp, last_seen, first_r, last_r;
    int g[$];
    int r[$];
    int exp_bp[3];
    logic [63:0] held;

    tbl[0] = '{1'b0, 1'b1, 64'h3FF0000000000000, 64'h4000000000000000, 64'h4008000000000000};
    tbl[1] = '{1'b1, 1'b0, 64'h3F8000003F800000, 64'h3F8000003F800000, 64'h4000000040000000};
    tbl[2] = '{1'b0, 1'b1, 64'h3FF8000000000000, 64'h3FD0000000000000, 64'h3FFC000000000000};
    tbl[3] = '{1'b1, 1'b0, 64'h400000003F000000, 64'h404000003E800000, 64'h40A000003F400000};
    tbl[4] = '{1'b0, 1'b0, 64'hC00000003F800000, 64'h3F8000003F800000, 64'hBF80000040000000};
    tbl[5] = '{1'b1, 1'b1, 64'h3FF0000000000000, 64'hBFF0000000000000, 64'h0000000000000000};

    rst_n = 1'b0; req_valid = 2'b00; req_mode = 2'b00; drain = 1'b0; rsp_ready = 2'b11;
    req_A0 = '0; req_B0 = '0; req_A1 = '0; req_B1 = '0;
    repeat (3) tick();

    // Reset release with requester 0 already waiting
    set_req(0, tbl[0].mode, tbl[0].a, tbl[0].b);
    req_valid = 2'b01;
    rst_n = 1'b1;
    #1;
    k = 0;
    while (fadd_clr === 1'b1 && k < 20) begin
      check("init_req_ready", 64'(req_ready), 64'd0);
      tick();
      k++;
    end
    check("init_clr_cycles", 64'(k), 64'(LATENCY));
    check("first_run_grant", 64'(req_ready), 64'd1);

    // Vector table: single operations, data and latency
    for (int i = 0; i < 6; i++) do_op(i);

    // Contention: both requesters valid for 6 cycles
    set_req(0, tbl[0].mode, tbl[0].a, tbl[0].b);
    set_req(1, tbl[1].mode, tbl[1].a, tbl[1].b);
    first_r = -1; last_r = -1;
    for (int c = 0; c < 16; c++) begin
      req_valid = (c < 6) ? 2'b11 : 2'b00;
      #1;
      if (req_ready == 2'b01) g.push_back(0);
      else if (req_ready == 2'b10) g.push_back(1);
      if (rsp_valid != 2'b00) begin
        r.push_back(rsp_valid == 2'b10 ? 1 : 0);
        if (first_r < 0) first_r = c;
        last_r = c;
      end
      tick();
    end
    check("cont_grant_count", 64'(g.size()), 64'd6);
    check("cont_rsp_count", 64'(r.size()), 64'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < g.size()) check("cont_grant_order", 64'(g[i]), 64'(i % 2));
      if (i < r.size()) check("cont_rsp_order", 64'(r[i]), 64'(i % 2));
    end
    check("cont_rsp_span", 64'(last_r - first_r), 64'd5);

    // Backpressure: requester 0 not ready while its result sits at the output
    set_req(0, tbl[2].mode, tbl[2].a, tbl[2].b);
    set_req(1, tbl[3].mode, tbl[3].a, tbl[3].b);
    req_valid = 2'b01; #1; check("bp_issue0", 64'(req_ready), 64'd1); tick();
    req_valid = 2'b10; #1; check("bp_issue1", 64'(req_ready), 64'd2); tick();
    req_valid = 2'b01; #1; check("bp_issue2", 64'(req_ready), 64'd1); tick();
    req_valid = 2'b00; rsp_ready = 2'b10;
    k = 0;
    while (rsp_valid !== 2'b01 && k < 20) begin tick(); k++; end
    held = rsp_data;
    req_valid = 2'b10;
    #1;
    for (int s = 0; s < 3; s++) begin
      check("bp_fadd_en", 64'(fadd_en), 64'd0);
      check("bp_no_issue", 64'(req_ready), 64'd0);
      check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      check("bp_data_hold", rsp_data, held);
      if (s < 2) tick();
    end
    rsp_ready = 2'b11; req_valid = 2'b00;
    #1;
    r.delete();
    for (int c = 0; c < 10; c++) begin
      if (rsp_valid != 2'b00) r.push_back(rsp_valid == 2'b10 ? 1 : 0);
      tick();
    end
    exp_bp = '{0, 1, 0};
    check("bp_rsp_count", 64'(r.size()), 64'd3);
    for (int i = 0; i < 3; i++)
      if (i < r.size()) check("bp_rsp_order", 64'(r[i]), 64'(exp_bp[i]));

    // Drain with three operations in flight
    req_valid = 2'b11;
    #1;
    repeat (3) tick();
    drain = 1'b1;
    #1;
    check("drain_blocks_req", 64'(req_ready), 64'd0);
    k = 0; nrsp = 0; last_seen = -1;
    while (idle !== 1'b1 && k < 30) begin
      if (rsp_valid != 2'b00) begin nrsp++; last_seen = k; end
      tick();
      k++;
    end
    check("drain_rsp_count", 64'(nrsp), 64'd3);
    check("drain_idle", 64'(idle), 64'd1);
    check("drain_idle_delay", 64'(k - last_seen), 64'd1);
    drain = 1'b0; req_valid = 2'b00;
    tick();

    // Reset with operations in flight: nothing may come back
    req_valid = 2'b11;
    #1;
    repeat (3) tick();
    req_valid = 2'b00;
    tick();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    #1;
    check("rerst_clr", 64'(fadd_clr), 64'd1);
    for (int c = 0; c < 12; c++) begin
      check("rerst_no_rsp", 64'(rsp_valid), 64'd0);
      tick();
    end
    do_op(1);

    // Randomized traffic, checked by the scoreboard every cycle
    for (int c = 0; c < 400; c++) begin
      req_valid = 2'($urandom_range(0, 3));
      req_mode  = 2'($urandom_range(0, 3));
      req_A0 = rnd_operand(req_mode[0]); req_B0 = rnd_operand(req_mode[0]);
      req_A1 = rnd_operand(req_mode[1]); req_B1 = rnd_operand(req_mode[1]);
      rsp_ready[0] = ($urandom_range(0, 3) != 0);
      rsp_ready[1] = ($urandom_range(0, 3) != 0);
      drain = ($urandom_range(0, 15) == 0);
      tick();
    end
    req_valid = 2'b00; rsp_ready = 2'b11; drain = 1'b0;
    repeat (12) tick();
    check("final_idle", 64'(idle), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
